// File: rtl/dm_bus_bridge_pkg.sv
// Shared definitions for the M-stage data-bus bridge: FSM encodings,
// default legal data range and the range-check helper.
package dm_bus_bridge_pkg;

    localparam logic [1:0] dmb_IDLE = 2'd0;
    localparam logic [1:0] dmb_REQ  = 2'd1;
    localparam logic [1:0] dmb_DONE = 2'd2;

    localparam logic [31:0] DM_BASE_DEFAULT    = 32'h0000_0000;
    localparam logic [31:0] DM_LIMIT_DEFAULT   = 32'h0000_3000;
    localparam int unsigned DM_TIMEOUT_DEFAULT = 255;

    // Single unsigned compare covers both bounds: addresses below base wrap high.
    function automatic logic dmb_in_range(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] limit);
        return (addr - base) < (limit - base);
    endfunction

endpackage

// File: rtl/dm_bus_bridge_timer.sv
// REQ-phase wait counter: cleared while idle, counts cycles without ack,
// flags the last permitted cycle.
module dm_bus_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/dm_bus_bridge.sv
// M-stage memory-bus sequencer: runs one req/ack transaction per memory
// instruction and stalls the pipeline until it completes, times out or is rejected.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// dmb_IDLE | waiting for a memory instruction; latches request on start
// dmb_REQ  | bus_req asserted, waiting for ack or timeout
// dmb_DONE | result registered, pipeline released for one cycle
module dm_bus_bridge
    import dm_bus_bridge_pkg::*;
#(
    parameter logic [31:0] DM_BASE        = DM_BASE_DEFAULT,
    parameter logic [31:0] DM_LIMIT       = DM_LIMIT_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = DM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_is_load,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_byteen,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        m_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_fault
);

    logic [1:0] state;
    logic       start;
    logic       in_range;
    logic       tmr_expired;
    logic       tmr_clr;
    logic       tmr_en;

    assign start    = m_valid & (m_is_load | (data_byteen != 4'b0000));
    assign in_range = dmb_in_range(data_addr, DM_BASE, DM_LIMIT);

    assign bus_req  = (state == dmb_REQ);
    assign m_stall  = ((state == dmb_IDLE) & start) | (state == dmb_REQ);

    assign tmr_clr  = (state == dmb_IDLE);
    assign tmr_en   = (state == dmb_REQ) & ~bus_ack;

    dm_bus_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= dmb_IDLE;
            data_rdata <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
            bus_we     <= 1'b0;
            bus_fault  <= 1'b0;
        end else begin
            case (state)
                dmb_IDLE: begin
                    if (start) begin
                        bus_addr  <= {data_addr[31:2], 2'b00};
                        bus_wdata <= data_wdata;
                        bus_we    <= ~m_is_load;
                        if (in_range) begin
                            bus_be <= m_is_load ? 4'b1111 : data_byteen;
                            state  <= dmb_REQ;
                        end else begin
                            // rejected access never drives the bus, so no enables
                            bus_be     <= 4'b0000;
                            data_rdata <= '0;
                            bus_fault  <= 1'b1;
                            state      <= dmb_DONE;
                        end
                    end
                end
                dmb_REQ: begin
                    if (bus_ack) begin
                        data_rdata <= bus_we ? 32'h0 : bus_rdata;
                        bus_be     <= 4'b0000;
                        state      <= dmb_DONE;
                    end else if (tmr_expired) begin
                        data_rdata <= '0;
                        bus_fault  <= 1'b1;
                        bus_be     <= 4'b0000;
                        state      <= dmb_DONE;
                    end
                end
                dmb_DONE: begin
                    state <= dmb_IDLE;
                end
                default: begin
                    state <= dmb_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_bus_bridge.sv
// Self-checking bench for dm_bus_bridge: directed cases plus randomized
// accesses compared against a per-access outcome model.
module tb_dm_bus_bridge;

    localparam int          TMO   = 4;
    localparam logic [31:0] LIMIT = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic        m_is_load;
    logic [31:0] data_addr;
    logic [3:0]  data_byteen;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        m_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_fault;

    int tests = 0;
    int fails = 0;

    logic [31:0] mdl_rdata;
    logic        mdl_fault;

    dm_bus_bridge #(
        .DM_BASE        (32'h0000_0000),
        .DM_LIMIT       (LIMIT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_valid     (m_valid),
        .m_is_load   (m_is_load),
        .data_addr   (data_addr),
        .data_byteen (data_byteen),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .m_stall     (m_stall),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .bus_fault   (bus_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One M-stage access; k = number of REQ cycles before ack (>= TMO means never).
    task automatic access(input logic ld, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input int k, input logic [31:0] rd);
        int          exp_stall;
        int          exp_req;
        int          stall_cnt;
        int          req_cnt;
        bit          done;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;

        exp_addr = addr & 32'hFFFF_FFFC;
        exp_be   = ld ? 4'hF : be;
        if (!(ld || be != 4'h0)) begin
            exp_stall = 0;
            exp_req   = 0;
        end else if (addr >= LIMIT) begin
            exp_stall = 1;
            exp_req   = 0;
            mdl_rdata = 32'h0;
            mdl_fault = 1'b1;
        end else if (k < TMO) begin
            exp_stall = k + 2;
            exp_req   = k + 1;
            mdl_rdata = ld ? rd : 32'h0;
        end else begin
            exp_stall = TMO + 1;
            exp_req   = TMO;
            mdl_rdata = 32'h0;
            mdl_fault = 1'b1;
        end

        stall_cnt = 0;
        req_cnt   = 0;
        done      = 1'b0;
        @(negedge clk);
        m_valid     = 1'b1;
        m_is_load   = ld;
        data_addr   = addr;
        data_byteen = be;
        data_wdata  = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (bus_req) begin
                chk("bus_addr", bus_addr, exp_addr);
                chk("bus_be", {28'h0, bus_be}, {28'h0, exp_be});
                chk("bus_we", {31'h0, bus_we}, {31'h0, ~ld});
                chk("bus_wdata", bus_wdata, wd);
                bus_ack   = (req_cnt == k);
                bus_rdata = bus_ack ? rd : $urandom();
                req_cnt++;
            end else begin
                bus_ack   = 1'($urandom_range(0, 1));
                bus_rdata = $urandom();
            end
            if (m_stall) begin
                stall_cnt++;
            end else begin
                chk("data_rdata", data_rdata, mdl_rdata);
                chk("bus_be_idle", {28'h0, bus_be}, 32'h0);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (done) begin
                m_valid = 1'b0;
                bus_ack = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        chk("access_finished", {31'h0, done}, 32'h1);
        chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        chk("req_cycles", 32'(req_cnt), 32'(exp_req));
        chk("bus_fault", {31'h0, bus_fault}, {31'h0, mdl_fault});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'h0, bus_req}, 32'h0);
        chk({tag, "_stall"}, {31'h0, m_stall}, 32'h0);
        chk({tag, "_rdata"}, data_rdata, 32'h0);
        chk({tag, "_fault"}, {31'h0, bus_fault}, 32'h0);
        chk({tag, "_addr"}, bus_addr, 32'h0);
        chk({tag, "_be"}, {28'h0, bus_be}, 32'h0);
        chk({tag, "_we"}, {31'h0, bus_we}, 32'h0);
        chk({tag, "_wdata"}, bus_wdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          saw_req;
        logic [31:0] a;
        logic [3:0]  be;
        logic        ld;

        reset       = 1'b0;
        m_valid     = 1'b0;
        m_is_load   = 1'b0;
        data_addr   = '0;
        data_byteen = '0;
        data_wdata  = '0;
        bus_ack     = 1'b0;
        bus_rdata   = '0;
        mdl_rdata   = '0;
        mdl_fault   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // zero-wait load, then store acked on the last permitted cycle
        access(1'b1, 32'h0000_0104, 4'h0, 32'hDEAD_BEEF, 0, 32'h1234_5678);
        access(1'b0, 32'h0000_0203, 4'b1000, 32'hAB00_0000, 3, 32'h5555_AAAA);
        // store with no enables is a no-op
        access(1'b0, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF, 0, 32'h0);
        // timeout: never acked
        access(1'b1, 32'h0000_0080, 4'h0, 32'h0, 99, 32'h0);

        // reset during the second REQ cycle
        @(negedge clk);
        m_valid     = 1'b1;
        m_is_load   = 1'b1;
        data_addr   = 32'h0000_0040;
        data_byteen = 4'h0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("second_req_cycle", {31'h0, bus_req}, 32'h1);
        reset   = 1'b0;
        m_valid = 1'b0;
        #1;
        mdl_rdata = 32'h0;
        mdl_fault = 1'b0;
        chk_reset_outputs("midreq_reset");
        @(negedge clk);
        reset   = 1'b1;
        saw_req = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus_req || m_stall) saw_req++;
        end
        chk("no_spurious_txn", 32'(saw_req), 32'h0);
        chk_reset_outputs("post_reset");

        // out-of-range at the limit, then fault must stay set
        access(1'b1, LIMIT, 4'h0, 32'h0, 0, 32'h7777_7777);
        access(1'b1, 32'h0000_2FFC, 4'h0, 32'h0, 1, 32'hCAFE_F00D);

        for (int i = 0; i < 40; i++) begin
            ld = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a = $urandom();
            else a = 32'($urandom_range(0, 32'h3FFF));
            access(ld, a, be, $urandom(), int'($urandom_range(0, TMO + 1)), $urandom());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dm_bus_bridge.md
Name: dm_bus_bridge

Overview:
- M-stage memory-bus sequencer, directly downstream of the M-stage load/store formatter.
- Consumes the formatter's word address, byte enables and positioned write data.
- Runs a req/ack transaction on an external variable-latency data bus and returns the raw 32-bit read word.
- Holds the whole pipeline stalled until the transaction completes, times out, or is rejected as out-of-range.

Parameters:
- DM_BASE, 32'h0000_0000: lowest legal data address.
- DM_LIMIT, 32'h0000_3000: first illegal address; legal range is DM_BASE <= addr < DM_LIMIT.
- TIMEOUT_CYCLES, 255: maximum number of REQ cycles without ack before the bridge abandons the access. Must be >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- m_valid  in  1  M stage holds a memory instruction.
- m_is_load  in  1  1 = load, 0 = store.
- data_addr  in  32  byte address from the formatter.
- data_byteen  in  4  store byte enables from the formatter.
- data_wdata  in  32  positioned store data from the formatter.
- data_rdata  out  32  raw read word returned to the formatter (registered).
- m_stall  out  1  freezes F/D/E/M; combinational.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write enable.
- bus_addr  out  32  word-aligned bus address.
- bus_be  out  4  bus byte enables.
- bus_wdata  out  32  bus write data.
- bus_ack  in  1  bus completion.
- bus_rdata  in  32  bus read data; valid with bus_ack.
- bus_fault  out  1  sticky flag; set on timeout or out-of-range access.

Behaviour:
- Reset (reset=0, asynchronous)
  - State goes to IDLE.
  - data_rdata, bus_addr, bus_wdata and the timeout counter clear to 0.
  - bus_be=0, bus_we=0, bus_fault=0.
  - bus_req drops immediately, including mid-transaction; there is no completion or retry after reset.
- States: IDLE, REQ, DONE.
- Start condition, evaluated in IDLE only: start = m_valid & (m_is_load | data_byteen != 0).
  - A store with byteen=0 is a no-op: no stall, no bus activity.
- m_stall = (state==IDLE & start) | (state==REQ).
  - m_stall is 0 in DONE, so the pipeline advances exactly once per access.
- IDLE, when start holds:
  - Latch bus_addr = {data_addr[31:2], 2'b00}, bus_be = m_is_load ? 4'b1111 : data_byteen, bus_wdata, and bus_we = ~m_is_load.
  - Clear the counter.
  - In range: go to REQ.
  - Out of range: go to DONE with data_rdata=0 and set bus_fault; no bus_req is issued.
- REQ:
  - bus_req=1; bus_addr, bus_be, bus_we and bus_wdata are held stable.
  - On bus_ack: data_rdata = bus_we ? 0 : bus_rdata; go to DONE.
  - Without ack: counter increments. When counter == TIMEOUT_CYCLES-1 with no ack, set bus_fault, data_rdata=0, go to DONE.
  - Ack on the timeout cycle counts as success; ack takes priority.
- DONE:
  - bus_req=0 and bus_be=0.
  - data_rdata holds its value until the next latch.
  - Next state is unconditionally IDLE; a new M-stage instruction is sampled there next cycle.
- Latency: if ack arrives k cycles after bus_req rises (k=0 means same cycle), the stall lasts k+2 cycles. A zero-wait access takes 3 cycles total.
- bus_ack outside REQ is ignored.
- bus_fault is cleared only by reset.
- data_addr[1:0] is not checked here; the formatter owns alignment.

Decomposition:
- Add to the shared def.v:
  - state encodings dmb_IDLE=2'd0, dmb_REQ=2'd1, dmb_DONE=2'd2;
  - the default DM range constants.
- Sub-module dm_bus_timer: resettable up-counter with clear, enable and expired outputs, sized $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Load from 0x0000_0104, bus_ack in the same cycle as bus_req with rdata 0x1234_5678 → bus_addr=0x104, bus_be=4'b1111, bus_we=0; m_stall high exactly 2 cycles; data_rdata=0x1234_5678 in DONE.
- Store data_addr=0x0000_0203, byteen=4'b1000, wdata=0xAB00_0000, ack after 3 cycles → bus_addr=0x200, bus_be=4'b1000, bus_we=1, bus_wdata=0xAB00_0000; stall 5 cycles; data_rdata=0.
- Store with byteen=0 and m_valid=1 → m_stall=0, bus_req never asserted, state stays IDLE.
- Load at 0x0000_3000 → no bus_req; stall 1 cycle; data_rdata=0; bus_fault=1 and stays 1.
- TIMEOUT_CYCLES=4, load, never ack → bus_req high 4 cycles then 0; bus_fault=1; data_rdata=0; stall 5 cycles.
- Assert reset low during the 2nd REQ cycle → bus_req=0 and m_stall=0 immediately; after release, IDLE with all outputs 0 and no spurious transaction.
